dsp_casc_slice: RTL and testbench

- Parametrised, vendor-independent behavioural model of one cascadable multiply-add slice for the FIOS Montgomery datapath.
- Replaces fixed-width, fixed-opmode primitive wrappers. Adds configurable operand width and pipeline depth, a compact mode set with accumulate and shifted-cascade terms, a pipeline stall, and a valid flag aligned with the data.
- Instances are chained through pcin_i/pcout_o to form the multi-word multiplier column.

---
 rtl/dsp_casc_pkg.sv | 24 ++
 rtl/dsp_pipe_reg.sv | 32 +++
 rtl/dsp_casc_slice.sv | 126 ++++++++++++
 tb/tb_dsp_casc_slice.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_casc_pkg.sv
// Shared types and helpers for the cascadable multiply-add slice.
package dsp_casc_pkg;

  // Default width of the internal accumulator and the cascade bus.
  localparam int DSP_P_W = 48;

  // ALU modes. X is the product zero-extended to P width.
  typedef enum logic [2:0] {
    MODE_ZERO        = 3'd0,  // P <= 0
    MODE_MUL         = 3'd1,  // P <= X
    MODE_MUL_C       = 3'd2,  // P <= X + C
    MODE_MUL_PCIN    = 3'd3,  // P <= X + pcin
    MODE_MUL_PCIN_SH = 3'd4,  // P <= X + (pcin >> SHIFT)
    MODE_MUL_ACC     = 3'd5,  // P <= X + P
    MODE_MUL_P_SH    = 3'd6,  // P <= X + (P >> SHIFT)
    MODE_C_ONLY      = 3'd7   // P <= C
  } mode_t;

  // Number of enabled edges from a_i/b_i sampling to the P load.
  function automatic int dsp_reg_level(input int abreg, input int mreg);
    return abreg + mreg + 1;
  endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// Delay line of configurable depth and width. Advances only while en is
// high and clears asynchronously. DEPTH = 0 degenerates to a plain wire.
module dsp_pipe_reg #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_regs
    logic [W-1:0] stage [DEPTH];

    // Shift the delay line by one position on every enabled edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/dsp_casc_slice.sv
// One cascadable multiply-add slice: registered A/B -> product M -> ALU -> P.
// Slices are chained through pcin_i/pcout_o to build a multi-word column.
//
// valid semantics: valid_i marks a_i/b_i as a real sample; there is no
// ready/back-pressure. valid_o is high exactly when P holds the result of a
// valid sample. ce_i = 0 freezes every register, so samples presented during
// a stall are dropped and valid_o/P hold their value.
module dsp_casc_slice
  import dsp_casc_pkg::*;
#(
  parameter int A_W     = 17,
  parameter int B_W     = 17,
  parameter int C_W     = 34,
  parameter int P_W     = DSP_P_W,
  parameter int P_OUT_W = 34,
  parameter int SHIFT   = 17,
  parameter int ABREG   = 1,
  parameter int MREG    = 1,
  parameter int CREG    = 1
) (
  input  logic               clock_i,
  input  logic               rst_n_i,
  input  logic               ce_i,
  input  logic               creg_en_i,
  input  logic               valid_i,
  input  logic [2:0]         mode_i,
  input  logic [A_W-1:0]     a_i,
  input  logic [B_W-1:0]     b_i,
  input  logic [C_W-1:0]     c_i,
  input  logic [P_W-1:0]     pcin_i,
  output logic [P_OUT_W-1:0] p_o,
  output logic [P_W-1:0]     pcout_o,
  output logic               valid_o
);

  localparam int M_W       = A_W + B_W;
  localparam int REG_LEVEL = dsp_reg_level(ABREG, MREG);

  // Reject parameter sets the datapath cannot represent.
  if (A_W + B_W > P_W) begin : g_chk_prod
    $error("dsp_casc_slice: A_W+B_W exceeds P_W");
  end
  if (SHIFT >= P_W) begin : g_chk_shift
    $error("dsp_casc_slice: SHIFT must be below P_W");
  end
  if (P_OUT_W > P_W) begin : g_chk_pout
    $error("dsp_casc_slice: P_OUT_W exceeds P_W");
  end
  if (ABREG < 0 || ABREG > 2 || MREG < 0 || MREG > 1 || CREG < 0 || CREG > 1)
  begin : g_chk_regs
    $error("dsp_casc_slice: illegal register stage count");
  end

  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  logic [M_W-1:0] m_d;
  logic [M_W-1:0] m_q;
  logic [C_W-1:0] c_q;
  logic           c_load;
  mode_t          mode_q;
  logic [P_W-1:0] p_q;
  logic [P_W-1:0] p_next;
  logic [P_W-1:0] x_ext;
  logic [P_W-1:0] c_ext;

  dsp_pipe_reg #(.W(A_W), .DEPTH(ABREG)) u_a_pipe (
    .clk(clock_i), .rst_n(rst_n_i), .en(ce_i), .d(a_i), .q(a_q)
  );

  dsp_pipe_reg #(.W(B_W), .DEPTH(ABREG)) u_b_pipe (
    .clk(clock_i), .rst_n(rst_n_i), .en(ce_i), .d(b_i), .q(b_q)
  );

  assign m_d = M_W'(a_q) * M_W'(b_q);

  dsp_pipe_reg #(.W(M_W), .DEPTH(MREG)) u_m_pipe (
    .clk(clock_i), .rst_n(rst_n_i), .en(ce_i), .d(m_d), .q(m_q)
  );

  // C is a loadable constant; the ALU always sees the pre-load value on the
  // edge that loads a new one.
  assign c_load = ce_i & creg_en_i;

  dsp_pipe_reg #(.W(C_W), .DEPTH(CREG)) u_c_pipe (
    .clk(clock_i), .rst_n(rst_n_i), .en(c_load), .d(c_i), .q(c_q)
  );

  // valid travels alongside the data so it lines up with P.
  dsp_pipe_reg #(.W(1), .DEPTH(REG_LEVEL)) u_valid_pipe (
    .clk(clock_i), .rst_n(rst_n_i), .en(ce_i), .d(valid_i), .q(valid_o)
  );

  assign x_ext = P_W'(m_q);
  assign c_ext = P_W'(c_q);

  // ALU: select the second operand by mode; sums wrap modulo 2^P_W.
  always_comb begin
    p_next = '0;
    case (mode_q)
      MODE_ZERO:        p_next = '0;
      MODE_MUL:         p_next = x_ext;
      MODE_MUL_C:       p_next = x_ext + c_ext;
      MODE_MUL_PCIN:    p_next = x_ext + pcin_i;
      MODE_MUL_PCIN_SH: p_next = x_ext + (pcin_i >> SHIFT);
      MODE_MUL_ACC:     p_next = x_ext + p_q;
      MODE_MUL_P_SH:    p_next = x_ext + (p_q >> SHIFT);
      MODE_C_ONLY:      p_next = c_ext;
      default:          p_next = '0;
    endcase
  end

  // Mode register (one stage ahead of P) and the P accumulator.
  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_q <= MODE_ZERO;
      p_q    <= '0;
    end else if (ce_i) begin
      mode_q <= mode_t'(mode_i);
      p_q    <= p_next;
    end
  end

  assign pcout_o = p_q;
  assign p_o     = p_q[P_OUT_W-1:0];

endmodule

// File: tb/tb_dsp_casc_slice.sv
// Bench for dsp_casc_slice with default parameters (latency 3, CREG = 1).
module tb_dsp_casc_slice;
  import dsp_casc_pkg::*;

  localparam int L = 3;

  // ---------------- clock / reset ----------------
  logic clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  logic        rst_n_i;
  logic        ce_i;
  logic        creg_en_i;
  logic        valid_i;
  logic [2:0]  mode_i;
  logic [16:0] a_i;
  logic [16:0] b_i;
  logic [33:0] c_i;
  logic [47:0] pcin_i;
  logic [33:0] p_o;
  logic [47:0] pcout_o;
  logic        valid_o;

  dsp_casc_slice dut (
    .clock_i   (clock_i),
    .rst_n_i   (rst_n_i),
    .ce_i      (ce_i),
    .creg_en_i (creg_en_i),
    .valid_i   (valid_i),
    .mode_i    (mode_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .c_i       (c_i),
    .pcin_i    (pcin_i),
    .p_o       (p_o),
    .pcout_o   (pcout_o),
    .valid_o   (valid_o)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // History of every enabled-edge input set; the result of enabled edge n is
  // derived from the sample taken L-1 enabled edges earlier, the mode from the
  // previous enabled edge, pcin from edge n and C as loaded before edge n.
  typedef struct packed {
    logic [16:0] a;
    logic [16:0] b;
    logic        v;
    logic [2:0]  mode;
    logic [33:0] c;
    logic        cen;
    logic [47:0] pcin;
  } smp_t;

  smp_t        hist[$];
  logic [47:0] m_p;
  logic [47:0] m_c;
  logic        m_v;
  logic [47:0] exp_q[$];
  logic        last_ce;

  task automatic model_reset();
    hist.delete();
    m_p = '0;
    m_c = '0;
    m_v = 1'b0;
  endtask

  task automatic model_edge(input smp_t s);
    int          n;
    int          k;
    logic [47:0] x;
    mode_t       md;
    hist.push_back(s);
    n = hist.size() - 1;
    k = n - L + 1;
    x = '0;
    if (k >= 0) x = 48'(hist[k].a) * 48'(hist[k].b);
    md = MODE_ZERO;
    if (n >= 1) md = mode_t'(hist[n-1].mode);
    case (md)
      MODE_ZERO:        m_p = '0;
      MODE_MUL:         m_p = x;
      MODE_MUL_C:       m_p = x + m_c;
      MODE_MUL_PCIN:    m_p = x + s.pcin;
      MODE_MUL_PCIN_SH: m_p = x + (s.pcin / 48'h2_0000);
      MODE_MUL_ACC:     m_p = x + m_p;
      MODE_MUL_P_SH:    m_p = x + (m_p / 48'h2_0000);
      default:          m_p = m_c;
    endcase
    m_v = (k >= 0) ? hist[k].v : 1'b0;
    if (s.cen) m_c = 48'(s.c);
  endtask

  // ---------------- driver ----------------
  task automatic step();
    smp_t s;
    logic ce_s;
    s.a    = a_i;
    s.b    = b_i;
    s.v    = valid_i;
    s.mode = mode_i;
    s.c    = c_i;
    s.cen  = creg_en_i;
    s.pcin = pcin_i;
    ce_s   = ce_i;
    @(posedge clock_i);
    if (ce_s) model_edge(s);
    last_ce = ce_s;
    #1;
    check("pcout", pcout_o, m_p);
    check("p_o", 48'(p_o), m_p & 48'h3_FFFF_FFFF);
    check("valid", 48'(valid_o), 48'(m_v));
  endtask

  task automatic idle(input int n);
    a_i = '0; b_i = '0; valid_i = 1'b0; creg_en_i = 1'b0; ce_i = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n_i = 1'b0; ce_i = 1'b1; creg_en_i = 1'b0; valid_i = 1'b0;
    mode_i = MODE_MUL; a_i = '0; b_i = '0; c_i = '0; pcin_i = '0;
    last_ce = 1'b0;
    model_reset();
    repeat (2) @(posedge clock_i);
    #1;
    check("rst_pcout", pcout_o, 48'h0);
    check("rst_valid", 48'(valid_o), 48'h0);
    @(negedge clock_i);
    rst_n_i = 1'b1;
    #1;

    // Latency: one valid 3*5 sample, result on the third enabled edge.
    a_i = 17'd3; b_i = 17'd5; valid_i = 1'b1; mode_i = MODE_MUL;
    step();
    check("lat_v0", 48'(valid_o), 48'h0);
    a_i = '0; b_i = '0; valid_i = 1'b0;
    step();
    check("lat_p1", pcout_o, 48'h0);
    step();
    check("lat_p", pcout_o, 48'd15);
    check("lat_v", 48'(valid_o), 48'h1);
    idle(L);

    // Accumulate four maximal squares.
    mode_i = MODE_MUL_ACC;
    for (int t = 0; t < 6; t++) begin
      a_i = (t < 4) ? 17'h1FFFF : 17'h0;
      b_i = a_i;
      valid_i = (t < 4);
      step();
    end
    check("acc4", pcout_o, 48'hF_FFF0_0004);

    // Shifted cascade term.
    mode_i = MODE_MUL_PCIN_SH; pcin_i = 48'h5_0000_0000;
    a_i = 17'd2; b_i = 17'd7; valid_i = 1'b1;
    step();
    a_i = '0; b_i = '0; valid_i = 1'b0;
    step();
    step();
    check("pcin_sh", pcout_o, 48'h2800E);
    pcin_i = '0;
    mode_i = MODE_MUL;
    idle(L);

    // C hold, then a load on the same edge as a C-using P load.
    mode_i = MODE_MUL_C;
    for (int t = 0; t < 8; t++) begin
      creg_en_i = (t == 0) || (t == 5);
      c_i       = (t == 0) ? 34'h3FF : ((t == 5) ? 34'h7 : 34'h123);
      a_i       = (t >= 1 && t <= 5) ? 17'd1 : 17'd0;
      b_i       = a_i;
      valid_i   = (t >= 1 && t <= 5);
      step();
      if (t >= 3 && t <= 4) check("c_hold", pcout_o, 48'h400);
      if (t == 5)           check("c_same_edge", pcout_o, 48'h400);
      if (t >= 6)           check("c_new", pcout_o, 48'h8);
    end
    creg_en_i = 1'b0;
    mode_i = MODE_MUL;
    idle(L + 1);

    // Stall mid-stream: results must come out in order, once each.
    exp_q.delete();
    begin
      int sent;
      sent = 0;
      for (int t = 0; t < 20; t++) begin
        if (t >= 4 && t < 9) begin
          ce_i = 1'b0;
          a_i = 17'($urandom); b_i = 17'($urandom); valid_i = 1'($urandom);
        end else begin
          ce_i = 1'b1;
          if (sent < 8) begin
            a_i = 17'(sent + 1); b_i = 17'd3; valid_i = 1'b1;
            exp_q.push_back(48'((sent + 1) * 3));
            sent++;
          end else begin
            a_i = '0; b_i = '0; valid_i = 1'b0;
          end
        end
        step();
        if (last_ce && valid_o) begin
          if (exp_q.size() == 0) check("sb_extra", pcout_o, 48'h0 - 48'h1);
          else check("sb_order", pcout_o, exp_q.pop_front());
        end
      end
      check("sb_empty", 48'(exp_q.size()), 48'h0);
    end
    ce_i = 1'b1;

    // Wrap: all-ones P plus a product of 1 rolls over to 0.
    mode_i = MODE_MUL_PCIN; pcin_i = 48'hFFFF_FFFF_FFFF;
    idle(2);
    check("wrap_ones", pcout_o, 48'hFFFF_FFFF_FFFF);
    mode_i = MODE_MUL_ACC;
    a_i = 17'd1; b_i = 17'd1; valid_i = 1'b1;
    step();
    a_i = '0; b_i = '0; valid_i = 1'b0;
    step();
    step();
    check("wrap_zero", pcout_o, 48'h0);
    pcin_i = '0;

    // Randomized traffic against the model.
    for (int t = 0; t < 300; t++) begin
      ce_i      = ($urandom_range(0, 9) != 0);
      creg_en_i = 1'($urandom);
      valid_i   = 1'($urandom);
      mode_i    = 3'($urandom_range(0, 7));
      a_i       = 17'($urandom);
      b_i       = 17'($urandom);
      c_i       = 34'({$urandom(), $urandom()});
      pcin_i    = 48'({$urandom(), $urandom()});
      step();
    end

    // Asynchronous reset with samples in flight.
    ce_i = 1'b1; mode_i = MODE_MUL; a_i = 17'd9; b_i = 17'd9; valid_i = 1'b1;
    step();
    step();
    @(posedge clock_i);
    #3;
    rst_n_i = 1'b0;
    #1;
    check("arst_pcout", pcout_o, 48'h0);
    check("arst_p_o", 48'(p_o), 48'h0);
    check("arst_valid", 48'(valid_o), 48'h0);
    model_reset();
    @(negedge clock_i);
    rst_n_i = 1'b1;
    a_i = '0; b_i = '0; valid_i = 1'b0;
    for (int t = 0; t < L + 1; t++) begin
      step();
      check("post_rst_valid", 48'(valid_o), 48'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
